// File: rtl/sram_pin_pkg.sv
// Shared constants for the on-chip SRAM pin responder and the controller-side monitors.
package sram_pin_pkg;
   localparam int CNT_W = 16;
   localparam logic [31:0] OOB_DATA_DEF = 32'hDEAD_BEEF;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WR_ACT  = 2'd1;
   localparam logic [1:0] ST_RD_WAIT = 2'd2;
   localparam logic [1:0] ST_RD_DRV  = 2'd3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
      return (v >= lim) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/sram_resp_array.sv
// Dual-port synchronous word array, write-first, no reset so it maps onto block RAM.
module sram_resp_array #(
   parameter int DEPTHW = 12,
   parameter int DATAW  = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [DEPTHW-1:0] waddr,
   input  logic [DATAW-1:0]  wdata,
   input  logic [DEPTHW-1:0] raddr,
   output logic [DATAW-1:0]  rdata
);
   logic [DATAW-1:0] mem [2**DEPTHW];
   logic [DATAW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (we && (waddr == raddr)) rdata_q <= wdata;
      else                        rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/sram_pin_responder.sv
// Answers asynchronous-SRAM pin strobes from an on-chip array, one 32-bit lane per instance.
module sram_pin_responder
   import sram_pin_pkg::*;
#(
   parameter int               ADDRW    = 19,
   parameter int               DATAW    = 32,
   parameter int               DEPTHW   = 12,
   parameter int               RD_LAT   = 2,
   parameter logic [DATAW-1:0] OOB_DATA = DATAW'(OOB_DATA_DEF),
   parameter logic [CNT_W-1:0] CNT_SAT  = '1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SRAM_CS_Pin,
   input  logic             SRAM_WR_Pin,
   input  logic             SRAM_OE_Pin,
   input  logic [ADDRW-1:0] SRAM_ADDR_Pin,
   input  logic [DATAW-1:0] SRAM_DATA_IN_Pin,
   output logic [DATAW-1:0] SRAM_DATA_OUT_Pin,
   output logic             SRAM_DATA_OE,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count,
   output logic             oob_err
);
   localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);
   // With a single-cycle latency the array port alone covers the wait.
   localparam logic [1:0] RD_ENTRY = (RD_LAT == 1) ? ST_RD_DRV : ST_RD_WAIT;

   logic             s_cs_q, s_wr_q, s_oe_q;
   logic [ADDRW-1:0] s_addr_q, addr_prev_q;
   logic [DATAW-1:0] s_data_q;

   logic [1:0]       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             oe_q, oe_d;
   logic             oob_q, oob_d;
   logic             rd_oob_q, rd_oob_d;
   logic [ADDRW-1:0] wa_q, wa_d;
   logic [DATAW-1:0] wd_q, wd_d;
   logic [DATAW-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

   logic             wr_dec, rd_dec, addr_oob, addr_chg, commit;
   logic [DATAW-1:0] ram_rdata, word;

   assign wr_dec   = !s_cs_q && !s_wr_q;
   assign rd_dec   = !s_cs_q && s_wr_q && !s_oe_q;
   assign addr_oob = |s_addr_q[ADDRW-1:DEPTHW];
   assign addr_chg = s_addr_q != addr_prev_q;
   assign rd_oob_d = addr_oob;
   assign word     = rd_oob_q ? OOB_DATA : ram_rdata;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      oe_d     = oe_q;
      wa_d     = wa_q;
      wd_d     = wd_q;
      hold_d   = hold_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      commit   = 1'b0;
      oob_d    = oob_q | ((wr_dec | rd_dec) & addr_oob);
      if (wr_dec) begin
         wa_d = s_addr_q;
         wd_d = s_data_q;
      end
      if (state_q == ST_RD_DRV) hold_d = word;
      case (state_q)
         ST_IDLE: begin
            if (wr_dec) state_d = ST_WR_ACT;
            else if (rd_dec) begin
               state_d = RD_ENTRY;
               cnt_d   = LAT_LOAD;
               oe_d    = (RD_LAT == 1) ? 1'b1 : oe_q;
            end
         end
         ST_WR_ACT: begin
            // End-of-write edge: the last latched word lands in the array.
            if (!wr_dec) begin
               commit   = 1'b1;
               wr_cnt_d = sat_inc(wr_cnt_q, CNT_SAT);
               state_d  = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (wr_dec) begin
               state_d = ST_WR_ACT;
               oe_d    = 1'b0;
            end else if (!rd_dec) begin
               state_d = ST_IDLE;
               oe_d    = 1'b0;
            end else if (addr_chg) begin
               state_d = RD_ENTRY;
               cnt_d   = LAT_LOAD;
               oe_d    = (RD_LAT == 1) ? 1'b1 : oe_q;
            end else if (cnt_q == 3'd1) begin
               state_d = ST_RD_DRV;
               oe_d    = 1'b1;
            end else cnt_d = cnt_q - 3'd1;
         end
         default: begin
            // ST_RD_DRV: OE stays up across an address restart so a sweep never releases the bus.
            if (!rd_dec) begin
               state_d  = ST_IDLE;
               oe_d     = 1'b0;
               rd_cnt_d = sat_inc(rd_cnt_q, CNT_SAT);
            end else if (addr_chg) begin
               state_d  = RD_ENTRY;
               cnt_d    = LAT_LOAD;
               rd_cnt_d = sat_inc(rd_cnt_q, CNT_SAT);
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s_cs_q      <= 1'b1;
         s_wr_q      <= 1'b1;
         s_oe_q      <= 1'b1;
         s_addr_q    <= '0;
         s_data_q    <= '0;
         addr_prev_q <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         oe_q        <= 1'b0;
         oob_q       <= 1'b0;
         rd_oob_q    <= 1'b0;
         wa_q        <= '0;
         wd_q        <= '0;
         hold_q      <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
      end else begin
         s_cs_q      <= SRAM_CS_Pin;
         s_wr_q      <= SRAM_WR_Pin;
         s_oe_q      <= SRAM_OE_Pin;
         s_addr_q    <= SRAM_ADDR_Pin;
         s_data_q    <= SRAM_DATA_IN_Pin;
         addr_prev_q <= s_addr_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         oe_q        <= oe_d;
         oob_q       <= oob_d;
         rd_oob_q    <= rd_oob_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
         hold_q      <= hold_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
      end
   end

   sram_resp_array #(.DEPTHW(DEPTHW), .DATAW(DATAW)) u_array (
      .clk  (CLK),
      .we   (commit && !(|wa_q[ADDRW-1:DEPTHW])),
      .waddr(wa_q[DEPTHW-1:0]),
      .wdata(wd_q),
      .raddr(s_addr_q[DEPTHW-1:0]),
      .rdata(ram_rdata)
   );

   assign SRAM_DATA_OUT_Pin = (state_q == ST_RD_DRV) ? word : hold_q;
   assign SRAM_DATA_OE      = oe_q;
   assign wr_count          = wr_cnt_q;
   assign rd_count          = rd_cnt_q;
   assign oob_err           = oob_q;
endmodule

// File: tb/tb_sram_pin_responder.sv
// Scoreboard bench for sram_pin_responder: pin-level writes/reads against expected words.
module tb_sram_pin_responder;
   localparam int          RD_LAT  = 2;
   localparam int          K       = RD_LAT + 1;
   // Saturation limit lowered so the counter ceiling is reachable in a short run.
   localparam logic [15:0] CNT_SAT = 16'd40;

   logic        CLK = 1'b0, RST = 1'b1;
   logic        cs = 1'b1, wr = 1'b1, oe_n = 1'b1;
   logic [18:0] addr = '0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        data_oe;
   logic [15:0] wr_count, rd_count;
   logic        oob_err;

   int          checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   int          exp_wr = 0, exp_rd = 0;

   sram_pin_responder #(.RD_LAT(RD_LAT), .CNT_SAT(CNT_SAT)) dut (
      .CLK(CLK), .RST(RST),
      .SRAM_CS_Pin(cs), .SRAM_WR_Pin(wr), .SRAM_OE_Pin(oe_n),
      .SRAM_ADDR_Pin(addr), .SRAM_DATA_IN_Pin(din),
      .SRAM_DATA_OUT_Pin(dout), .SRAM_DATA_OE(data_oe),
      .wr_count(wr_count), .rd_count(rd_count), .oob_err(oob_err)
   );

   always #5 CLK = ~CLK;

   function automatic int sat(input int v);
      return (v >= int'(CNT_SAT)) ? v : v + 1;
   endfunction

   task automatic idle_pins();
      cs = 1'b1; wr = 1'b1; oe_n = 1'b1;
   endtask

   task automatic do_write(input logic [18:0] a, input logic [31:0] d);
      @(posedge CLK); #1;
      cs = 1'b0; wr = 1'b0; oe_n = 1'b1; addr = a; din = d;
      @(posedge CLK); #1;
      idle_pins();
      repeat (3) @(posedge CLK);
      exp_wr = sat(exp_wr);
   endtask

   task automatic do_read(input logic [18:0] a, input logic [31:0] e, input string name);
      int k;
      logic got;
      logic [31:0] want;
      exp_q.push_back(e);
      @(posedge CLK); #1;
      cs = 1'b0; wr = 1'b1; oe_n = 1'b0; addr = a;
      k = 0; got = 1'b0;
      while (!got && k < 20) begin
         @(negedge CLK);
         k++;
         if (data_oe === 1'b1) got = 1'b1;
      end
      want = exp_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_oe: SRAM_DATA_OE never rose within %0d cycles", name, k);
      end else begin
         checks++;
         if (dout !== want) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", name, dout, want);
         end
         checks++;
         if (k - 1 !== RD_LAT + 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, k - 1, RD_LAT + 1);
         end
      end
      @(posedge CLK); #1;
      idle_pins();
      repeat (3) @(posedge CLK);
      exp_rd = sat(exp_rd);
   endtask

   task automatic check_counts(input string name);
      checks++;
      if (wr_count !== 16'(exp_wr)) begin
         errors++;
         $display("FAIL %s_wr_count: got %0d expected %0d", name, wr_count, exp_wr);
      end
      checks++;
      if (rd_count !== 16'(exp_rd)) begin
         errors++;
         $display("FAIL %s_rd_count: got %0d expected %0d", name, rd_count, exp_rd);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({dout, data_oe, wr_count, rd_count, oob_err} !== '0) begin
         errors++;
         $display("FAIL %s: got dout=%h oe=%b wr=%0d rd=%0d oob=%b expected all zero",
                  name, dout, data_oe, wr_count, rd_count, oob_err);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #2;
      check_reset_outputs("reset_state");
      RST = 1'b0;
      repeat (2) @(posedge CLK);
   endtask

   task automatic test_single();
      do_write(19'h00010, 32'hA5A5_0001);
      do_read(19'h00010, 32'hA5A5_0001, "single");
      check_counts("single");
      checks++;
      if (oob_err !== 1'b0) begin
         errors++;
         $display("FAIL single_oob: got %b expected 0", oob_err);
      end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++) do_write(19'h00100 + 19'(i), 32'hC0DE_0000 + 32'(i * 257));
      for (int i = 0; i < 16; i++) exp_q.push_back(32'hC0DE_0000 + 32'(i * 257));
      for (int c = 0; c <= 16 * K + 1; c++) begin
         @(posedge CLK); #1;
         if (c % K == 0 && c < 16 * K) begin
            cs = 1'b0; wr = 1'b1; oe_n = 1'b0; addr = 19'h00100 + 19'(c / K);
         end
         if (c == 16 * K) idle_pins();
         @(negedge CLK);
         if (c >= K) begin
            checks++;
            if (data_oe !== 1'b1) begin
               errors++;
               $display("FAIL sweep_oe: cycle %0d got %b expected 1", c, data_oe);
            end
         end
         if (c >= K && c % K == 0) begin
            logic [31:0] want;
            want = exp_q.pop_front();
            checks++;
            if (dout !== want) begin
               errors++;
               $display("FAIL sweep_data: word %0d got %h expected %h", c / K - 1, dout, want);
            end
         end
      end
      repeat (3) @(posedge CLK);
      for (int i = 0; i < 16; i++) exp_rd = sat(exp_rd);
      check_counts("sweep");
   endtask

   task automatic test_oob();
      do_write(19'h00000, 32'h0BAD_0000);
      checks++;
      if (oob_err !== 1'b0) begin
         errors++;
         $display("FAIL oob_pre: got %b expected 0", oob_err);
      end
      do_write(19'h40000, 32'hFFFF_0000);
      checks++;
      if (oob_err !== 1'b1) begin
         errors++;
         $display("FAIL oob_flag: got %b expected 1", oob_err);
      end
      check_counts("oob_write");
      do_read(19'h00000, 32'h0BAD_0000, "oob_alias");
      do_read(19'h40000, 32'hDEAD_BEEF, "oob_read");
      check_counts("oob");
   endtask

   task automatic test_read_abort();
      @(posedge CLK); #1;
      cs = 1'b0; wr = 1'b1; oe_n = 1'b0; addr = 19'h00030; din = 32'h600D_F00D;
      @(posedge CLK); #1;
      wr = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         checks++;
         if (data_oe !== 1'b0) begin
            errors++;
            $display("FAIL abort_oe: got %b expected 0", data_oe);
         end
      end
      @(posedge CLK); #1;
      idle_pins();
      repeat (3) @(posedge CLK);
      exp_wr = sat(exp_wr);
      check_counts("abort");
      do_read(19'h00030, 32'h600D_F00D, "abort_commit");
   endtask

   task automatic test_reset_mid_op();
      do_write(19'h00020, 32'h1111_2222);
      @(posedge CLK); #1;
      cs = 1'b0; wr = 1'b0; oe_n = 1'b1; addr = 19'h00020; din = 32'h1234_5678;
      repeat (3) @(posedge CLK);
      #2 RST = 1'b1;
      #1 check_reset_outputs("reset_mid_write");
      idle_pins();
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      exp_wr = 0; exp_rd = 0;
      do_read(19'h00020, 32'h1111_2222, "reset_keep");
      // Reset while driving read data must release the bus immediately.
      @(posedge CLK); #1;
      cs = 1'b0; wr = 1'b1; oe_n = 1'b0; addr = 19'h00020;
      repeat (6) @(negedge CLK);
      checks++;
      if (data_oe !== 1'b1) begin
         errors++;
         $display("FAIL reset_rd_pre: got oe %b expected 1", data_oe);
      end
      #1 RST = 1'b1;
      #1 check_reset_outputs("reset_mid_read");
      idle_pins();
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      exp_wr = 0; exp_rd = 0;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 45; i++) begin
         do_write(19'h00200 + 19'(i % 8), 32'(i));
         if (exp_wr == int'(CNT_SAT) - 1 && i < 44) begin
            checks++;
            if (wr_count !== CNT_SAT - 16'd1) begin
               errors++;
               $display("FAIL sat_below: got %0d expected %0d", wr_count, CNT_SAT - 16'd1);
            end
         end
      end
      check_counts("saturation");
      do_read(19'h00204, 32'd44, "sat_data");
   endtask

   initial begin
      test_reset();
      test_single();
      test_sweep();
      test_oob();
      test_read_abort();
      test_reset_mid_op();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
